// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared note/entry definitions and sequencer state encoding
package sound_pkg;

    localparam int NOTE_W  = 5;
    localparam int DUR_W   = 4;
    localparam int ENTRY_W = NOTE_W + DUR_W;
    localparam logic [NOTE_W-1:0] REST = 5'd0;

    localparam int NOTE_HI = 8;
    localparam int NOTE_LO = 4;
    localparam int DUR_HI  = 3;
    localparam int DUR_LO  = 0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_PLAY  = 3'd3,
        ST_GAP   = 3'd4,
        ST_END   = 3'd5
    } state_t;

    function automatic logic [ENTRY_W-1:0] ent(input logic [NOTE_W-1:0] n, input logic [DUR_W-1:0] d);
        return {n, d};
    endfunction

endpackage

// File: rtl/melody_sequencer_rom.sv
// rtl/melody_sequencer_rom.sv - song_rom: registered case-table melody store
module song_rom
    import sound_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int SONG_SEL = 0
) (
    input  logic                        clk,
    input  logic [$clog2(SONG_LEN)-1:0] addr,
    output logic [ENTRY_W-1:0]          data
);

    logic [31:0]        a;
    logic [ENTRY_W-1:0] word;

    assign a = 32'(addr);

    // Table 0 is the product melody; tables 1 and 2 are short bring-up songs.
    always_comb begin
        word = '0;
        case (SONG_SEL)
            1: begin
                case (a)
                    32'd0:   word = ent(5'd3, 4'd1);
                    32'd1:   word = ent(5'd7, 4'd2);
                    default: word = ent(5'd0, 4'd0);
                endcase
            end
            2: begin
                case (a)
                    32'd0:   word = ent(5'd5, 4'd1);
                    32'd1:   word = ent(5'd9, 4'd1);
                    32'd2:   word = ent(5'd12, 4'd1);
                    32'd3:   word = ent(5'd17, 4'd1);
                    default: word = ent(5'd0, 4'd0);
                endcase
            end
            default: begin
                case (a)
                    32'd0:   word = ent(5'd5, 4'd2);
                    32'd1:   word = ent(5'd5, 4'd2);
                    32'd2:   word = ent(5'd6, 4'd2);
                    32'd3:   word = ent(5'd8, 4'd2);
                    32'd4:   word = ent(5'd8, 4'd2);
                    32'd5:   word = ent(5'd6, 4'd2);
                    32'd6:   word = ent(5'd5, 4'd2);
                    32'd7:   word = ent(5'd3, 4'd2);
                    32'd8:   word = ent(5'd1, 4'd2);
                    32'd9:   word = ent(5'd1, 4'd2);
                    32'd10:  word = ent(5'd3, 4'd2);
                    32'd11:  word = ent(5'd5, 4'd2);
                    32'd12:  word = ent(5'd5, 4'd3);
                    32'd13:  word = ent(5'd3, 4'd1);
                    32'd14:  word = ent(5'd3, 4'd4);
                    default: word = ent(5'd0, 4'd0);
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        data <= word;
    end

endmodule

// File: rtl/melody_sequencer.sv
// rtl/melody_sequencer.sv - steps the song ROM and drives the tone generator note code
module melody_sequencer
    import sound_pkg::*;
#(
    parameter int SONG_LEN = 32,
    parameter int TICK_DIV = 5_000_000,
    parameter int GAP_CYC  = 500_000,
    parameter int SONG_SEL = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        stop,
    input  logic                        loop_en,
    output logic [NOTE_W-1:0]           note,
    output logic                        playing,
    output logic                        done,
    output logic [$clog2(SONG_LEN)-1:0] step_idx
);

    localparam int     AW       = $clog2(SONG_LEN);
    localparam longint PLAY_MAX = 15 * longint'(TICK_DIV) - 1;
    localparam longint GAP_MAX  = (GAP_CYC > 0) ? longint'(GAP_CYC) - 1 : 0;
    localparam longint CNT_MAX  = (PLAY_MAX > GAP_MAX) ? PLAY_MAX : GAP_MAX;
    localparam int     CW       = $clog2(CNT_MAX + 1);

    state_t             state;
    state_t             adv_state;
    logic [AW-1:0]      idx;
    logic [AW-1:0]      adv_idx;
    logic [CW-1:0]      cnt;
    logic [ENTRY_W-1:0] rom_data;
    logic [NOTE_W-1:0]  rom_note;
    logic [DUR_W-1:0]   rom_dur;

    song_rom #(
        .SONG_LEN (SONG_LEN),
        .SONG_SEL (SONG_SEL)
    ) u_rom (
        .clk  (clk),
        .addr (idx),
        .data (rom_data)
    );

    assign rom_note = rom_data[NOTE_HI:NOTE_LO];
    assign rom_dur  = rom_data[DUR_HI:DUR_LO];

    // Leaving PLAY/GAP: the last ROM slot counts as end of song even without a marker.
    always_comb begin
        adv_state = ST_LOAD;
        adv_idx   = idx + AW'(1);
        if (idx == '1) begin
            adv_state = ST_END;
            adv_idx   = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stop) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
            note  <= REST;
        end else begin
            case (state)
                ST_IDLE: begin
                    note <= REST;
                    if (start) begin
                        idx   <= '0;
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state <= ST_CHECK;
                end
                ST_CHECK: begin
                    if (rom_dur == '0) begin
                        state <= ST_END;
                    end else begin
                        note  <= rom_note;
                        cnt   <= CW'(longint'(rom_dur) * longint'(TICK_DIV) - 1);
                        state <= ST_PLAY;
                    end
                end
                ST_PLAY: begin
                    if (cnt == '0) begin
                        note <= REST;
                        if (GAP_CYC > 0) begin
                            cnt   <= CW'(GAP_MAX);
                            state <= ST_GAP;
                        end else begin
                            idx   <= adv_idx;
                            state <= adv_state;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        idx   <= adv_idx;
                        state <= adv_state;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                ST_END: begin
                    idx   <= '0;
                    state <= loop_en ? ST_LOAD : ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // A looping END cycle still counts as playing so the flag stays high across the wrap.
    assign playing  = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_PLAY) ||
                      (state == ST_GAP) || ((state == ST_END) && loop_en);
    assign done     = (state == ST_END) && !loop_en && !stop;
    assign step_idx = idx;

endmodule
